// File: rtl/rtp_result_pkg.sv
// Shared types for the hit-result collector: FSM state encoding, the
// default "no hit" distance, and the beat carried from the traversal core.
package rtp_result_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [31:0] MISS_T_DEFAULT = 32'h7F7F_FFFF;

  typedef struct packed {
    logic [31:0] hitT;
    logic [31:0] ray_id;
  } result_beat_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous input buffer for result beats. DEPTH must be a power of two.
// The head entry is presented combinationally on dout whenever not empty.
module result_fifo
  import rtp_result_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  result_beat_t din,
  output result_beat_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  result_beat_t   mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hit_result_collector.sv
// Collects per-ray hit distances from the traversal core into a result RAM
// indexed by ray id, tracking written flags, counts and error conditions.
// Build option: RESULT_MIN_KEEP_EN -- when defined, a duplicate id only
// replaces the stored hitT if it is smaller; otherwise the last write wins.
module hit_result_collector
  import rtp_result_pkg::*;
#(
  parameter int          RAY_NUM    = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MISS_T     = MISS_T_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_start,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [31:0]                io_in_hitT,
  input  logic [31:0]                io_in_ray_id,
  input  logic                       io_rtp_finish,
  input  logic [$clog2(RAY_NUM)-1:0] io_rd_addr,
  output logic [31:0]                io_rd_hitT,
  output logic                       io_rd_written,
  output logic                       io_done,
  output logic [31:0]                io_ray_count,
  output logic [31:0]                io_miss_count,
  output logic [63:0]                io_cycle_count,
  output logic                       io_err
);

  localparam int          AW        = $clog2(RAY_NUM);
  localparam logic [31:0] RAY_NUM_W = 32'(RAY_NUM);

  state_t           state;
  result_beat_t     fifo_din;
  result_beat_t     fifo_dout;
  result_beat_t     pend_beat;
  logic             pend_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             active;
  logic             push;
  logic             pop;
  logic             start_clear;
  logic             id_ok;
  logic             dup;
  logic             keep;
  logic             mem_we;
  logic [AW-1:0]    waddr;
  logic [RAY_NUM-1:0] written;
  logic [31:0]      mem [RAY_NUM];

  assign active      = (state == ST_COLLECT) || (state == ST_DRAIN);
  assign io_in_ready = active && !fifo_full;
  assign push        = io_in_valid && io_in_ready;
  assign pop         = active && !fifo_empty;
  assign start_clear = io_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign io_done     = (state == ST_DONE);

  assign fifo_din.hitT   = io_in_hitT;
  assign fifo_din.ray_id = io_in_ray_id;

  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write-stage decode for the beat popped on the previous cycle.
  assign id_ok = (pend_beat.ray_id < RAY_NUM_W);
  assign waddr = pend_beat.ray_id[AW-1:0];
  assign dup   = written[waddr];
`ifdef RESULT_MIN_KEEP_EN
  assign keep  = !dup || (pend_beat.hitT[30:0] < mem[waddr][30:0]);
`else
  assign keep  = 1'b1;
`endif
  assign mem_we = pend_valid && id_ok && keep;

  // Run-control FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (io_start) state <= ST_COLLECT;
        ST_COLLECT: if (io_rtp_finish) state <= ST_DRAIN;
        // A beat accepted on the final drain cycle must not be stranded in the FIFO.
        ST_DRAIN:   if (fifo_empty && !pend_valid && !push) state <= ST_DONE;
        ST_DONE:    if (io_start) state <= ST_COLLECT;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Pop stage: one beat per cycle moves from the FIFO head to the write stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= pop;
    end
    if (pop) pend_beat <= fifo_dout;
  end

  // Result RAM write; contents are not reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[waddr] <= pend_beat.hitT;
  end

  // Written flags, counters and sticky error.
  always_ff @(posedge clock) begin
    if (reset || start_clear) begin
      written        <= '0;
      io_ray_count   <= '0;
      io_miss_count  <= '0;
      io_cycle_count <= '0;
      io_err         <= 1'b0;
    end else begin
      if (pend_valid) begin
        if (!id_ok || dup) begin
          io_err <= 1'b1;
        end else begin
          written[waddr] <= 1'b1;
          if (io_ray_count != '1) io_ray_count <= io_ray_count + 32'd1;
          if ((pend_beat.hitT == MISS_T) && (io_miss_count != '1))
            io_miss_count <= io_miss_count + 32'd1;
        end
      end
      if (active && (io_cycle_count != '1)) io_cycle_count <= io_cycle_count + 64'd1;
    end
  end

  // Synchronous read port; a same-cycle write is not forwarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_rd_hitT    <= '0;
      io_rd_written <= 1'b0;
    end else begin
      io_rd_hitT    <= mem[io_rd_addr];
      io_rd_written <= written[io_rd_addr];
    end
  end

endmodule

// File: tb/tb_hit_result_collector.sv
// Directed bench for hit_result_collector with a readout scoreboard.
module tb_hit_result_collector;

  localparam int          RAY_NUM    = 64;
  localparam int          FIFO_DEPTH = 8;
  localparam int          AW         = $clog2(RAY_NUM);
  localparam logic [31:0] MISS       = 32'h7F7F_FFFF;
  localparam int          PERIOD     = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [31:0]   io_in_hitT;
  logic [31:0]   io_in_ray_id;
  logic          io_rtp_finish;
  logic [AW-1:0] io_rd_addr;
  logic [31:0]   io_rd_hitT;
  logic          io_rd_written;
  logic          io_done;
  logic [31:0]   io_ray_count;
  logic [31:0]   io_miss_count;
  logic [63:0]   io_cycle_count;
  logic          io_err;

  int checks = 0;
  int errors = 0;
  time t_start;
  time t_done;

  typedef struct {
    int          addr;
    logic [31:0] hitT;
    logic        wr;
  } sb_t;
  sb_t exp_q[$];

  always #(PERIOD/2) clk = ~clk;

  hit_result_collector #(
    .RAY_NUM    (RAY_NUM),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MISS_T     (MISS)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .io_start       (io_start),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_in_hitT     (io_in_hitT),
    .io_in_ray_id   (io_in_ray_id),
    .io_rtp_finish  (io_rtp_finish),
    .io_rd_addr     (io_rd_addr),
    .io_rd_hitT     (io_rd_hitT),
    .io_rd_written  (io_rd_written),
    .io_done        (io_done),
    .io_ray_count   (io_ray_count),
    .io_miss_count  (io_miss_count),
    .io_cycle_count (io_cycle_count),
    .io_err         (io_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run();
    io_rtp_finish = 1'b0;
    io_start = 1'b1;
    @(posedge clk);
    t_start = $time;
    #1;
    io_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] id, input logic [31:0] hitT);
    int budget;
    budget = 0;
    io_in_valid  = 1'b1;
    io_in_ray_id = id;
    io_in_hitT   = hitT;
    while (!io_in_ready && budget < 100) begin
      tick(1);
      budget++;
    end
    if (!io_in_ready) begin
      errors++;
      $display("FAIL send_timeout observed=ready_low expected=ready_high id=%0d", id);
    end else begin
      tick(1);
    end
    io_in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (!io_done && budget < 200) begin
      @(posedge clk);
      t_done = $time;
      #1;
      budget++;
    end
    if (!io_done) begin
      errors++;
      $display("FAIL done_timeout observed=done_low expected=done_high");
    end
  endtask

  task automatic sb_push(input int addr, input logic [31:0] hitT, input logic wr);
    sb_t e;
    e.addr = addr;
    e.hitT = hitT;
    e.wr   = wr;
    exp_q.push_back(e);
  endtask

  task automatic sb_drain(input string tag);
    sb_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      io_rd_addr = AW'(e.addr);
      tick(1);
      check({tag, "_written"}, 64'(io_rd_written), 64'(e.wr));
      if (e.wr) check({tag, "_hitT"}, 64'(io_rd_hitT), 64'(e.hitT));
    end
  endtask

  initial begin
    reset = 1'b1;
    io_start = 1'b0;
    io_in_valid = 1'b0;
    io_in_hitT = '0;
    io_in_ray_id = '0;
    io_rtp_finish = 1'b0;
    io_rd_addr = '0;
    tick(3);

    // Reset state
    check("rst_ready", 64'(io_in_ready), 64'd0);
    check("rst_done", 64'(io_done), 64'd0);
    check("rst_err", 64'(io_err), 64'd0);
    check("rst_ray", 64'(io_ray_count), 64'd0);
    check("rst_miss", 64'(io_miss_count), 64'd0);
    check("rst_cycle", io_cycle_count, 64'd0);
    check("rst_rd_hitT", 64'(io_rd_hitT), 64'd0);
    check("rst_rd_written", 64'(io_rd_written), 64'd0);
    reset = 1'b0;
    tick(2);

    // Basic run: three results, one miss
    start_run();
    check("basic_ready", 64'(io_in_ready), 64'd1);
    send(0, 32'h3F80_0000); sb_push(0, 32'h3F80_0000, 1'b1);
    send(1, 32'h4000_0000); sb_push(1, 32'h4000_0000, 1'b1);
    send(2, MISS);          sb_push(2, MISS, 1'b1);
    sb_push(3, 32'h0, 1'b0);
    io_rtp_finish = 1'b1;
    wait_done();
    check("basic_ray", 64'(io_ray_count), 64'd3);
    check("basic_miss", 64'(io_miss_count), 64'd1);
    check("basic_err", 64'(io_err), 64'd0);
    check("basic_cycle", io_cycle_count, 64'((t_done - t_start) / PERIOD));
    tick(3);
    check("basic_cycle_hold", io_cycle_count, 64'((t_done - t_start) / PERIOD));
    check("basic_done_hold", 64'(io_done), 64'd1);
    check("basic_ready_done", 64'(io_in_ready), 64'd0);
    sb_drain("basic");

    // Out-of-range id, then a normal beat
    start_run();
    check("oor_err_cleared", 64'(io_err), 64'd0);
    check("oor_ray_cleared", 64'(io_ray_count), 64'd0);
    send(RAY_NUM, 32'h4040_0000);
    tick(3);
    check("oor_err", 64'(io_err), 64'd1);
    check("oor_ray_unchanged", 64'(io_ray_count), 64'd0);
    send(7, 32'h4080_0000); sb_push(7, 32'h4080_0000, 1'b1);
    sb_push(0, 32'h0, 1'b0);
    io_rtp_finish = 1'b1;
    wait_done();
    check("oor_ray", 64'(io_ray_count), 64'd1);
    check("oor_err_sticky", 64'(io_err), 64'd1);
    sb_drain("oor");

    // Duplicate ids
    start_run();
    send(5, 32'h4040_0000);
    send(5, 32'h3F80_0000); sb_push(5, 32'h3F80_0000, 1'b1);
    send(6, 32'h3F80_0000);
    send(6, 32'h4040_0000);
`ifdef RESULT_MIN_KEEP_EN
    sb_push(6, 32'h3F80_0000, 1'b1);
`else
    sb_push(6, 32'h4040_0000, 1'b1);
`endif
    io_rtp_finish = 1'b1;
    wait_done();
    check("dup_err", 64'(io_err), 64'd1);
    check("dup_ray", 64'(io_ray_count), 64'd2);
    sb_drain("dup");

    // Backpressure with the write path stalled
    start_run();
    force dut.pop = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      send(32'(10 + i), 32'h3000_0000 + 32'(i));
      sb_push(10 + i, 32'h3000_0000 + 32'(i), 1'b1);
    end
    check("bp_ready_full", 64'(io_in_ready), 64'd0);
    io_in_valid  = 1'b1;
    io_in_ray_id = 32'(10 + FIFO_DEPTH);
    io_in_hitT   = 32'h3000_0000 + 32'(FIFO_DEPTH);
    tick(3);
    check("bp_ready_held", 64'(io_in_ready), 64'd0);
    check("bp_ray_stalled", 64'(io_ray_count), 64'd0);
    release dut.pop;
    for (int i = FIFO_DEPTH; i < FIFO_DEPTH + 4; i++) begin
      send(32'(10 + i), 32'h3000_0000 + 32'(i));
      sb_push(10 + i, 32'h3000_0000 + 32'(i), 1'b1);
    end
    io_rtp_finish = 1'b1;
    wait_done();
    check("bp_ray", 64'(io_ray_count), 64'(FIFO_DEPTH + 4));
    check("bp_err", 64'(io_err), 64'd0);
    sb_drain("bp");

    // Finish with buffered beats: stays in DRAIN until written
    start_run();
    force dut.pop = 1'b0;
    send(40, 32'h3F00_0000); sb_push(40, 32'h3F00_0000, 1'b1);
    send(41, MISS);          sb_push(41, MISS, 1'b1);
    send(42, 32'h3E00_0000); sb_push(42, 32'h3E00_0000, 1'b1);
    io_rtp_finish = 1'b1;
    tick(3);
    check("drain_not_done", 64'(io_done), 64'd0);
    check("drain_ray_zero", 64'(io_ray_count), 64'd0);
    check("drain_cycle_run", io_cycle_count, 64'(($time - 1 - t_start) / PERIOD));
    release dut.pop;
    wait_done();
    check("drain_ray", 64'(io_ray_count), 64'd3);
    check("drain_miss", 64'(io_miss_count), 64'd1);
    check("drain_cycle", io_cycle_count, 64'((t_done - t_start) / PERIOD));
    tick(4);
    check("drain_cycle_hold", io_cycle_count, 64'((t_done - t_start) / PERIOD));
    sb_drain("drain");

    // Reset mid-collect, then a fresh run
    start_run();
    send(30, 32'h3C00_0000);
    send(RAY_NUM + 3, 32'h3C00_0000);
    tick(4);
    check("midrst_err_pre", 64'(io_err), 64'd1);
    reset = 1'b1;
    tick(2);
    check("midrst_ray", 64'(io_ray_count), 64'd0);
    check("midrst_miss", 64'(io_miss_count), 64'd0);
    check("midrst_cycle", io_cycle_count, 64'd0);
    check("midrst_err", 64'(io_err), 64'd0);
    check("midrst_ready", 64'(io_in_ready), 64'd0);
    check("midrst_done", 64'(io_done), 64'd0);
    reset = 1'b0;
    tick(1);
    start_run();
    io_rd_addr = AW'(30);
    tick(1);
    check("midrst_written_clear", 64'(io_rd_written), 64'd0);
    send(31, 32'h3D00_0000); sb_push(31, 32'h3D00_0000, 1'b1);
    sb_push(30, 32'h0, 1'b0);
    io_rtp_finish = 1'b1;
    wait_done();
    check("midrst_ray_new", 64'(io_ray_count), 64'd1);
    check("midrst_err_new", 64'(io_err), 64'd0);
    sb_drain("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
